// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational ROM, and buffers {pc, inst}
// words for decode behind a valid/ready handshake, with branch redirect flush.
module inst_fetch_unit #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned INST_W    = 16,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(BUF_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] buf_pc_q   [BUF_DEPTH];
  logic [INST_W-1:0] buf_inst_q [BUF_DEPTH];

  logic valid, pop, push;

  always_comb begin
    valid = (count_q != '0);
    pop   = valid & ready_i;
    // A pop frees the slot the push needs, so a full buffer still streams.
    push  = ~redirect_i & ((count_q != Full) | pop);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
    end else if (push) begin
      buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
      buf_inst_q[wr_ptr_q] <= inst_i;
    end
  end

  always_comb begin
    addr_o  = fetch_pc_q;
    valid_o = valid;
    inst_o  = valid ? buf_inst_q[rd_ptr_q] : '0;
    pc_o    = valid ? buf_pc_q[rd_ptr_q] : '0;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch-side master of the 7-bit-address / 16-bit-word instruction ROM interface.
- Owns the program counter and drives the ROM address.
- Captures the combinational ROM word into a small instruction buffer and presents {pc, inst} to decode with a valid/ready handshake.
- Accepts a branch redirect from execute (e.g. a taken BNE), which flushes buffered words and restarts fetch at the target.

Parameters:
- ADDR_W, 7: ROM address and PC width; PC wraps modulo 2^ADDR_W.
- INST_W, 16: instruction word width.
- BUF_DEPTH, 2: instruction buffer entries; legal values are 2 and 4 (power of two).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr_o  output  ADDR_W  ROM address; driven directly from the fetch_pc register.
- inst_i  input  INST_W  ROM data; combinational function of addr_o, valid in the same cycle.
- redirect_i  input  1  branch taken; flush and reload the PC.
- redirect_pc_i  input  ADDR_W  branch target PC, sampled when redirect_i=1.
- valid_o  output  1  buffer head holds a valid instruction.
- ready_i  input  1  decode accepts the head this cycle.
- inst_o  output  INST_W  head instruction word; 0 when valid_o=0.
- pc_o  output  ADDR_W  PC of the head instruction; 0 when valid_o=0.

Behaviour:
- State:
  - fetch_pc[ADDR_W-1:0].
  - Circular buffer of BUF_DEPTH entries, each {pc, inst}.
  - Read pointer rd_ptr and write pointer wr_ptr, each log2(BUF_DEPTH) bits.
  - count, 0..BUF_DEPTH.
- Reset (rst_n=0, asynchronous):
  - fetch_pc=0, rd_ptr=wr_ptr=0, count=0, buffer contents cleared to 0.
  - Outputs: addr_o=0, valid_o=0, inst_o=0, pc_o=0.
- Per-cycle control:
  - pop = valid_o & ready_i.
  - push = ~redirect_i & ((count<BUF_DEPTH) | pop).
- Push action: write {fetch_pc, inst_i} at wr_ptr, wr_ptr+1, fetch_pc <= fetch_pc+1.
  - Increment is modulo 2^ADDR_W, so 127 -> 0 with no flag.
- Pop action: rd_ptr+1.
- count update: count <= count + push - pop.
  - Push and pop in the same cycle leave count unchanged.
  - When full, a same-cycle pop permits the push.
- Redirect (redirect_i=1) takes priority over everything:
  - count<=0, rd_ptr<=wr_ptr<=0, fetch_pc<=redirect_pc_i.
  - No push that cycle, even if space exists.
  - A pop in the redirect cycle is still a valid handoff: decode consumed the head; it is not re-presented.
  - Back-to-back redirects: each cycle reloads fetch_pc; the last one wins.
- Stall: with ready_i=0 and count==BUF_DEPTH, fetch_pc and addr_o hold, and inst_i is ignored.
- Outputs:
  - valid_o = (count!=0).
  - inst_o/pc_o = buffer[rd_ptr] when valid_o, else 0.
  - Outputs are purely registered state: no combinational path from inst_i or ready_i to any output.
- Latency:
  - First valid_o rises on the first rising edge after rst_n deasserts.
  - After a redirect edge, valid_o is 0 for exactly one cycle; the target instruction appears on the following edge.
- Throughput: one instruction per cycle when ready_i is held high.
- Handshake rule: while valid_o=1 and ready_i=0, inst_o and pc_o stay stable until a pop or a redirect.
- Reset asserted mid-operation: immediate return to reset state; all buffered instructions are discarded.
- Opcode-agnostic: the block never decodes inst_i.

Test Plan:
- Bench ROM model returns mem[a]=16'hA000+a.
- Scenario 1: release reset, ready_i=1 for 5 cycles -> valid_o=1 from the first edge; (pc_o,inst_o) = (0,A000),(1,A001),(2,A002),(3,A003),(4,A004), one per cycle.
- Scenario 2: ready_i=0 from reset for 6 cycles -> count saturates at 2, addr_o holds at 2, head stays (0,A000); then ready_i=1 -> (0,A000),(1,A001),(2,A002) in consecutive cycles with no gap and no duplicates.
- Scenario 3: streaming, redirect_i=1 with redirect_pc_i=7'd5 while head is pc 2 and ready_i=1 -> pc 2 consumed, valid_o=0 for the next cycle, then (5,A005),(6,A006); pc 3 and pc 4 are never presented.
- Scenario 4: redirect to 7'd126 with ready_i=1 -> pc_o sequence 126, 127, 0, 1 with inst A07E, A07F, A000, A001 (wrap check).
- Scenario 5: random ready_i (50%) over 300 cycles with random redirects at 5% -> scoreboard confirms every accepted pc follows the previous accepted pc+1 or the last redirect target, inst == A000+pc, and inst_o/pc_o are stable while stalled.
- Scenario 6: assert rst_n=0 mid-stream with count=2, between clock edges -> valid_o, inst_o, pc_o, addr_o go to 0 immediately; after release, fetch restarts at pc 0.
